// File: rtl/ppm_frame_ctrl.sv
// ppm_frame_ctrl: frame-level sequencer for the PPM receive path.
//
// Sits between the preamble detector, the 2-bit symbol demodulator and the
// 4-symbol byte assembler. A detected preamble realigns the assembler and
// opens the symbol gate. Byte 0 of a frame is the payload length. That many
// payload bytes are then pushed into a small valid/ready output FIFO. Each
// frame ends with a one-cycle done or error pulse.
//
// Ports:
//   clk16          receiver clock, 16x symbol-slot rate
//   rst_n          asynchronous active-low reset
//   sync_det_i     one-cycle pulse: preamble found
//   sym_pulse_i    one-cycle pulse: a 2-bit symbol has been decided
//   sym_err_i      erasure flag, qualified by sym_pulse_i
//   sym_en_o       symbol gate; assembler strobe = sym_pulse & sym_en
//   asm_clr_n_o    registered active-low assembler clear
//   byte_rdy_i     assembler byte-complete level
//   byte_in_i      assembled byte
//   m_data_o       FIFO head byte (0 while empty)
//   m_valid_o      FIFO not empty
//   m_ready_i      downstream accept
//   frame_busy_o   high while aligning or receiving header/payload
//   frame_len_o    latched header length
//   frame_done_o   one-cycle pulse: frame completed
//   frame_err_o    one-cycle pulse: frame aborted
//   err_code_o     latched abort cause: 01 timeout, 10 erasure,
//                  11 bad length or FIFO overflow

module ppm_frame_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk16,
    input  logic       rst_n,
    input  logic       sync_det_i,
    input  logic       sym_pulse_i,
    input  logic       sym_err_i,
    output logic       sym_en_o,
    output logic       asm_clr_n_o,
    input  logic       byte_rdy_i,
    input  logic [7:0] byte_in_i,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic       frame_busy_o,
    output logic [7:0] frame_len_o,
    output logic       frame_done_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    // The timeout matures in the cycle the counter would step onto
    // TIMEOUT_CYC-1, i.e. when the current count is TIMEOUT_CYC-2.
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 2);
    localparam logic [7:0]      MaxLen  = 8'(MAX_LEN);

    localparam logic [1:0] ErrTmo = 2'b01;
    localparam logic [1:0] ErrSym = 2'b10;
    localparam logic [1:0] ErrLen = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StHdr,
        StPay,
        StDone,
        StErr
    } state_e;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      rem_q, rem_d;
    logic [7:0]      frame_len_q, frame_len_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            byte_rdy_q;
    logic            sym_en_q, sym_en_d;
    logic            asm_clr_n_q, asm_clr_n_d;
    logic            frame_busy_q, frame_busy_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PtrW:0] wr_q, rd_q;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic byte_stb;
    logic erasure;
    logic tmo_hit;
    logic bad_len;
    logic ovf;
    logic abort;
    logic [1:0] abort_code;

    assign byte_stb = byte_rdy_i & ~byte_rdy_q;
    assign erasure  = sym_pulse_i & sym_err_i;
    assign tmo_hit  = ~sym_pulse_i & (tmo_q == TmoLast);
    assign bad_len  = (byte_in_i == 8'd0) || (byte_in_i > MaxLen);

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[PtrW] != rd_q[PtrW]) &&
                        (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign pop        = ~fifo_empty & m_ready_i;
    assign ovf        = byte_stb & fifo_full & ~pop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        rem_d       = rem_q;
        frame_len_d = frame_len_q;
        err_code_d  = err_code_q;
        push        = 1'b0;
        abort       = 1'b0;
        abort_code  = ErrLen;

        unique case (state_q)
            StIdle: begin
                if (sync_det_i) begin
                    state_d = StAlign;
                end
            end

            StAlign: begin
                tmo_d   = '0;
                state_d = StHdr;
            end

            StHdr: begin
                tmo_d = sym_pulse_i ? '0 : tmo_q + 1'b1;
                if (erasure) begin
                    abort      = 1'b1;
                    abort_code = ErrSym;
                end else if (byte_stb && bad_len) begin
                    frame_len_d = byte_in_i;
                    abort       = 1'b1;
                    abort_code  = ErrLen;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    abort_code = ErrTmo;
                end else if (byte_stb) begin
                    frame_len_d = byte_in_i;
                    rem_d       = byte_in_i;
                    state_d     = StPay;
                end
            end

            StPay: begin
                tmo_d = sym_pulse_i ? '0 : tmo_q + 1'b1;
                if (erasure) begin
                    abort      = 1'b1;
                    abort_code = ErrSym;
                end else if (ovf) begin
                    // Byte is dropped; whatever is already queued stays.
                    abort      = 1'b1;
                    abort_code = ErrLen;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    abort_code = ErrTmo;
                end else if (byte_stb) begin
                    push  = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 8'd1) begin
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            StErr: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            state_d    = StErr;
            err_code_d = abort_code;
        end

        // Output registers follow the state being entered, so they line up
        // exactly with the state they describe.
        sym_en_d     = (state_d == StHdr) || (state_d == StPay);
        asm_clr_n_d  = (state_d != StAlign);
        frame_busy_d = (state_d == StAlign) || (state_d == StHdr) || (state_d == StPay);
        frame_done_d = (state_d == StDone);
        frame_err_d  = (state_d == StErr);
    end

    // ------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tmo_q        <= '0;
            rem_q        <= 8'd0;
            frame_len_q  <= 8'd0;
            err_code_q   <= 2'b00;
            byte_rdy_q   <= 1'b0;
            sym_en_q     <= 1'b0;
            asm_clr_n_q  <= 1'b1;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            rem_q        <= rem_d;
            frame_len_q  <= frame_len_d;
            err_code_q   <= err_code_d;
            byte_rdy_q   <= byte_rdy_i;
            sym_en_q     <= sym_en_d;
            asm_clr_n_q  <= asm_clr_n_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    // When full, a simultaneous push overwrites the head slot that is
    // being popped in the same cycle, which is safe because the read is
    // combinational.
    always_ff @(posedge clk16) begin
        if (push) begin
            fifo_mem[wr_q[PtrW-1:0]] <= byte_in_i;
        end
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // An erasure closes the gate in the same cycle so the bad symbol never
    // reaches the assembler.
    assign sym_en_o     = sym_en_q & ~erasure;
    assign asm_clr_n_o  = asm_clr_n_q;
    assign m_valid_o    = ~fifo_empty;
    assign m_data_o     = fifo_empty ? 8'h00 : fifo_mem[rd_q[PtrW-1:0]];
    assign frame_busy_o = frame_busy_q;
    assign frame_len_o  = frame_len_q;
    assign frame_done_o = frame_done_q;
    assign frame_err_o  = frame_err_q;
    assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// tb_ppm_frame_ctrl: self-checking bench for ppm_frame_ctrl.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// on the falling edge. A cycle-by-cycle vector table covers a normal frame;
// hand-written sequences cover length errors, timeout, erasure priority,
// overflow with backpressure and asynchronous reset mid-frame.

module tb_ppm_frame_ctrl;

    logic       clk16 = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_det = 1'b0;
    logic       sym_pulse = 1'b0;
    logic       sym_err = 1'b0;
    logic       sym_en;
    logic       asm_clr_n;
    logic       byte_rdy = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       frame_busy;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    logic mrdy_nxt = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk16 = ~clk16;

    ppm_frame_ctrl #(
        .TIMEOUT_CYC (64),
        .MAX_LEN     (32),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk16        (clk16),
        .rst_n        (rst_n),
        .sync_det_i   (sync_det),
        .sym_pulse_i  (sym_pulse),
        .sym_err_i    (sym_err),
        .sym_en_o     (sym_en),
        .asm_clr_n_o  (asm_clr_n),
        .byte_rdy_i   (byte_rdy),
        .byte_in_i    (byte_in),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .frame_busy_o (frame_busy),
        .frame_len_o  (frame_len),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err),
        .err_code_o   (err_code)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, return at mid-cycle.
    task automatic cycle_in(input logic sync, input logic pulse, input logic serr,
                            input logic rdy, input logic [7:0] din);
        @(posedge clk16);
        #1;
        sync_det  = sync;
        sym_pulse = pulse;
        sym_err   = serr;
        byte_rdy  = rdy;
        byte_in   = din;
        m_ready   = mrdy_nxt;
        @(negedge clk16);
    endtask

    task automatic idle();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Preamble, align cycle, then a header byte strobe.
    task automatic hdr_frame(input logic [7:0] len);
        cycle_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1, len);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, ".sym_en"}, sym_en, 1'b0);
        chk1({tag, ".asm_clr_n"}, asm_clr_n, 1'b1);
        chk1({tag, ".m_valid"}, m_valid, 1'b0);
        chk8({tag, ".m_data"}, m_data, 8'h00);
        chk1({tag, ".busy"}, frame_busy, 1'b0);
        chk8({tag, ".len"}, frame_len, 8'h00);
        chk1({tag, ".done"}, frame_done, 1'b0);
        chk1({tag, ".err"}, frame_err, 1'b0);
        chk2({tag, ".code"}, err_code, 2'b00);
    endtask

    typedef struct {
        logic [3:0] in;     // {sync_det, sym_pulse, sym_err, byte_rdy}
        logic [7:0] din;
        logic [2:0] en_clr_v; // {sym_en, asm_clr_n, m_valid}
        logic [7:0] data;
        logic       busy;
        logic [7:0] len;
        logic       done;
        logic       ferr;
    } vec_t;

    vec_t vecs[14];

    logic [7:0] ovf_bytes[5];

    initial begin
        // Normal frame: header 3, payload A5 3C FF, m_ready held high.
        vecs[0]  = '{4'b1000, 8'h00, 3'b010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 8'h00, 3'b000, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{4'b0100, 8'h00, 3'b110, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{4'b0001, 8'h03, 3'b110, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{4'b0001, 8'h03, 3'b110, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 8'h00, 3'b110, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[6]  = '{4'b0001, 8'hA5, 3'b110, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[7]  = '{4'b0000, 8'h00, 3'b111, 8'hA5, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[8]  = '{4'b0001, 8'h3C, 3'b110, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[9]  = '{4'b0101, 8'h3C, 3'b111, 8'h3C, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[10] = '{4'b0000, 8'h00, 3'b110, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[11] = '{4'b0001, 8'hFF, 3'b110, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 8'h00, 3'b011, 8'hFF, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[13] = '{4'b0000, 8'h00, 3'b010, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0};

        ovf_bytes[0] = 8'h11;
        ovf_bytes[1] = 8'h22;
        ovf_bytes[2] = 8'h33;
        ovf_bytes[3] = 8'h44;
        ovf_bytes[4] = 8'h55;

        // Reset
        repeat (2) @(posedge clk16);
        @(negedge clk16);
        chk_reset_vals("rst");
        @(posedge clk16);
        #2 rst_n = 1'b1;

        // 1. Table-driven normal frame
        mrdy_nxt = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle_in(vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0], vecs[i].din);
            chk1($sformatf("vec%0d.sym_en", i), sym_en, vecs[i].en_clr_v[2]);
            chk1($sformatf("vec%0d.asm_clr_n", i), asm_clr_n, vecs[i].en_clr_v[1]);
            chk1($sformatf("vec%0d.m_valid", i), m_valid, vecs[i].en_clr_v[0]);
            chk8($sformatf("vec%0d.m_data", i), m_data, vecs[i].data);
            chk1($sformatf("vec%0d.busy", i), frame_busy, vecs[i].busy);
            chk8($sformatf("vec%0d.len", i), frame_len, vecs[i].len);
            chk1($sformatf("vec%0d.done", i), frame_done, vecs[i].done);
            chk1($sformatf("vec%0d.err", i), frame_err, vecs[i].ferr);
            chk2($sformatf("vec%0d.code", i), err_code, 2'b00);
        end

        // 2. Bad lengths: 0 and MAX_LEN+1
        for (int f = 0; f < 2; f++) begin
            logic [7:0] l;
            l = (f == 0) ? 8'h00 : 8'h21;
            hdr_frame(l);
            chk1($sformatf("badlen%0d.sym_en_hdr", f), sym_en, 1'b1);
            idle();
            chk1($sformatf("badlen%0d.err", f), frame_err, 1'b1);
            chk2($sformatf("badlen%0d.code", f), err_code, 2'b11);
            chk8($sformatf("badlen%0d.len", f), frame_len, l);
            chk1($sformatf("badlen%0d.sym_en", f), sym_en, 1'b0);
            chk1($sformatf("badlen%0d.valid", f), m_valid, 1'b0);
            idle();
            chk1($sformatf("badlen%0d.err_after", f), frame_err, 1'b0);
            chk1($sformatf("badlen%0d.sym_en_after", f), sym_en, 1'b0);
            chk2($sformatf("badlen%0d.code_hold", f), err_code, 2'b11);
        end

        // 3. Timeout after one payload byte
        hdr_frame(8'h02);
        idle();
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);       // last pulse, cycle P
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);       // P+1
        idle();                                         // P+2
        chk1("tmo.valid", m_valid, 1'b1);
        chk8("tmo.data", m_data, 8'h5A);
        for (int k = 3; k <= 63; k++) idle();
        chk1("tmo.err_p63", frame_err, 1'b0);
        chk1("tmo.busy_p63", frame_busy, 1'b1);
        idle();                                         // P+64
        chk1("tmo.err", frame_err, 1'b1);
        chk2("tmo.code", err_code, 2'b01);
        chk1("tmo.done", frame_done, 1'b0);
        idle();
        chk1("tmo.err_after", frame_err, 1'b0);
        chk1("tmo.busy_after", frame_busy, 1'b0);

        // 4. Erasure in the cycle the timeout matures (MAX_LEN header accepted)
        hdr_frame(8'h20);
        idle();
        chk1("era.busy_pay", frame_busy, 1'b1);
        chk1("era.no_err_maxlen", frame_err, 1'b0);
        chk8("era.len", frame_len, 8'h20);
        cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);       // cycle P
        for (int k = 1; k <= 62; k++) idle();
        chk1("era.sym_en_p62", sym_en, 1'b1);
        cycle_in(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);       // P+63
        chk1("era.sym_en_drop", sym_en, 1'b0);
        idle();
        chk1("era.err", frame_err, 1'b1);
        chk2("era.code", err_code, 2'b10);
        idle();
        chk1("era.single_pulse", frame_err, 1'b0);
        chk2("era.code_hold", err_code, 2'b10);

        // 5. Backpressure and overflow
        mrdy_nxt = 1'b0;
        hdr_frame(8'h05);
        idle();
        for (int i = 0; i < 4; i++) begin
            cycle_in(1'b0, 1'b0, 1'b0, 1'b1, ovf_bytes[i]);
            idle();
            chk1($sformatf("ovf.valid%0d", i), m_valid, 1'b1);
            chk8($sformatf("ovf.head%0d", i), m_data, 8'h11);
        end
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1, ovf_bytes[4]);
        chk1("ovf.err_early", frame_err, 1'b0);
        idle();
        chk1("ovf.err", frame_err, 1'b1);
        chk2("ovf.code", err_code, 2'b11);
        chk1("ovf.done", frame_done, 1'b0);
        chk8("ovf.head_kept", m_data, 8'h11);
        mrdy_nxt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk1($sformatf("drain.valid%0d", i), m_valid, 1'b1);
            chk8($sformatf("drain.data%0d", i), m_data, ovf_bytes[i]);
        end
        idle();
        chk1("drain.empty", m_valid, 1'b0);

        // 6. Asynchronous reset mid-payload, then a 1-byte frame
        mrdy_nxt = 1'b0;
        hdr_frame(8'h03);
        idle();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
        idle();
        chk1("arst.pre_valid", m_valid, 1'b1);
        chk8("arst.pre_data", m_data, 8'h77);
        chk1("arst.pre_busy", frame_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(posedge clk16);
        #2 rst_n = 1'b1;
        mrdy_nxt = 1'b1;
        hdr_frame(8'h01);
        idle();
        chk1("post.busy", frame_busy, 1'b1);
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1, 8'h9C);
        idle();
        chk1("post.done", frame_done, 1'b1);
        chk1("post.err", frame_err, 1'b0);
        chk1("post.valid", m_valid, 1'b1);
        chk8("post.data", m_data, 8'h9C);
        chk8("post.len", frame_len, 8'h01);
        idle();
        chk1("post.done_after", frame_done, 1'b0);
        chk1("post.valid_after", m_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
